// File: rtl/taxi_ram_pkg.sv
// Shared types for the taxi RAM port front-end: controller FSM states and a
// request record sized for the widest port configuration in use.
package taxi_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_ctrl_state_t;

    localparam int RAM_REQ_ADDR_W_MAX = 32;
    localparam int RAM_REQ_DATA_W_MAX = 64;
    localparam int RAM_REQ_STRB_W_MAX = RAM_REQ_DATA_W_MAX / 8;

    typedef struct packed {
        logic [RAM_REQ_ADDR_W_MAX-1:0] addr;
        logic                          wr;
        logic [RAM_REQ_DATA_W_MAX-1:0] data;
        logic [RAM_REQ_STRB_W_MAX-1:0] strb;
    } ram_req_t;

    // Width of a counter that must hold every value 0..depth inclusive.
    function automatic int credit_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/taxi_ram_port_resp_fifo.sv
// Response FIFO for taxi_ram_port_ctrl: first-word-fall-through output,
// registered full/empty flags, DEPTH must be a power of two >= 2.
module taxi_ram_port_resp_fifo
    import taxi_ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [PTR_W:0]    count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en && !full_reg;
    assign rd_ok = rd_en && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            empty_reg <= (count_next == '0);
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = empty_reg ? '0 : mem_reg[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/taxi_ram_port_ctrl.sv
// Valid/ready front-end for one block-RAM port with credit-based read flow control.
// Optional zero-fill engine after reset: define TAXI_RAM_PORT_CTRL_INIT_EN.
module taxi_ram_port_ctrl
    import taxi_ram_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STRB_W     = DATA_W / 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] req_wr_data,
    input  logic [STRB_W-1:0] req_wr_strb,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,

    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [STRB_W-1:0] ram_wr_strb,
    input  logic [DATA_W-1:0] ram_rd_data,

    output logic              busy
);

    localparam int CNT_W = credit_cnt_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    ram_ctrl_state_t   state_reg;
    logic              busy_reg;
    logic              init_wr;
    logic [ADDR_W-1:0] init_addr;

    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [RD_LAT-1:0] rd_vld_reg;

    logic              req_accept;
    logic              rd_accept;
    logic              resp_pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef TAXI_RAM_PORT_CTRL_INIT_EN
    logic [ADDR_W-1:0] init_addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            busy_reg      <= 1'b1;
            init_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    init_addr_reg <= init_addr_reg + ADDR_W'(1);
                    if (&init_addr_reg) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    // Zero-fill drives the port directly; rst keeps the port idle while held.
    assign init_wr   = (state_reg == ST_INIT) && !rst;
    assign init_addr = init_addr_reg;
`else
    always_ff @(posedge clk) begin
        state_reg <= ST_RUN;
    end

    assign busy_reg  = 1'b0;
    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    assign busy       = busy_reg;
    assign req_ready  = !rst && !busy_reg && (state_reg == ST_RUN) && (cnt_reg < CNT_MAX);
    assign req_accept = req_valid && req_ready;
    assign rd_accept  = req_accept && !req_wr;
    assign resp_valid = !fifo_empty;
    assign resp_pop   = resp_valid && resp_ready;

    always_comb begin
        ram_en      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr    = req_addr;
        ram_wr_data = req_wr_data;
        ram_wr_strb = req_wr_strb;
        if (init_wr) begin
            ram_en      = 1'b1;
            ram_wr_en   = 1'b1;
            ram_addr    = init_addr;
            ram_wr_data = '0;
            ram_wr_strb = '1;
        end else if (req_accept) begin
            ram_en    = 1'b1;
            ram_wr_en = req_wr;
        end
    end

    // Credits cover reads in the RAM pipeline plus FIFO entries, so a push never overflows.
    always_comb begin
        cnt_next = cnt_reg;
        case ({rd_accept, resp_pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_rd_vld
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        rd_vld_reg[gi] <= 1'b0;
                    end else begin
                        rd_vld_reg[gi] <= rd_accept;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        rd_vld_reg[gi] <= 1'b0;
                    end else begin
                        rd_vld_reg[gi] <= rd_vld_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign fifo_push = rd_vld_reg[RD_LAT-1];

    taxi_ram_port_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .srst    (rst),
        .wr_en   (fifo_push),
        .wr_data (ram_rd_data),
        .rd_en   (resp_pop),
        .rd_data (resp_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst && fifo_push) begin
            assert (!fifo_full) else $error("taxi_ram_port_ctrl: response push into a full FIFO");
        end
    end

endmodule

// File: tb/tb_taxi_ram_port_ctrl.sv
// Directed scoreboard bench for taxi_ram_port_ctrl with a behavioural RAM model;
// adds the zero-fill checks when TAXI_RAM_PORT_CTRL_INIT_EN is defined.
module tb_taxi_ram_port_ctrl;
    import taxi_ram_pkg::*;

`ifdef TAXI_RAM_PORT_CTRL_INIT_EN
    localparam int ADDR_W = 4;
    localparam logic BUSY_RST = 1'b1;
    localparam logic READY_FIRST = 1'b0;
`else
    localparam int ADDR_W = 8;
    localparam logic BUSY_RST = 1'b0;
    localparam logic READY_FIRST = 1'b1;
`endif
    localparam int DATA_W = 16;
    localparam int STRB_W = 2;
    localparam int RD_LAT = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int NWORDS = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_wr = 1'b0;
    logic [DATA_W-1:0] req_wr_data = '0;
    logic [STRB_W-1:0] req_wr_strb = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_data;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wr_data;
    logic [STRB_W-1:0] ram_wr_strb;
    logic [DATA_W-1:0] ram_rd_data;
    logic              busy;

    taxi_ram_port_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STRB_W     (STRB_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wr      (req_wr),
        .req_wr_data (req_wr_data),
        .req_wr_strb (req_wr_strb),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_data (ram_wr_data),
        .ram_wr_strb (ram_wr_strb),
        .ram_rd_data (ram_rd_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pattern(input int i);
        return 16'hA500 ^ DATA_W'(i * 3 + 1);
    endfunction

    // Behavioural RAM with RD_LAT read pipeline, driven only by the DUT's RAM port.
    logic [DATA_W-1:0] ram_mem [NWORDS];
    logic [DATA_W-1:0] ram_pipe [RD_LAT];
    logic              preload = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NWORDS; i++) ram_mem[i] <= pattern(i);
        end else if (ram_en) begin
            if (ram_wr_en) begin
                for (int b = 0; b < STRB_W; b++)
                    if (ram_wr_strb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
            end else begin
                ram_pipe[0] <= ram_mem[ram_addr];
            end
        end
        for (int s = 1; s < RD_LAT; s++) ram_pipe[s] <= ram_pipe[s-1];
    end
    assign ram_rd_data = ram_pipe[RD_LAT-1];

    logic [DATA_W-1:0] ref_mem [NWORDS];
    logic [DATA_W-1:0] exp_q [$];
    int                pop_cyc_q [$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                n_pop = 0;
    logic              acc_last = 1'b0;
    logic [DATA_W-1:0] last_resp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: settle, account accepts/pops against the scoreboard, advance.
    task automatic tick();
        #1;
        acc_last = req_valid && req_ready;
        if (acc_last) begin
            if (req_wr) begin
                for (int b = 0; b < STRB_W; b++)
                    if (req_wr_strb[b]) ref_mem[req_addr][8*b +: 8] = req_wr_data[8*b +: 8];
            end else begin
                exp_q.push_back(ref_mem[req_addr]);
            end
        end
        if (resp_valid && resp_ready) begin
            n_pop++;
            pop_cyc_q.push_back(cyc);
            last_resp = resp_data;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_resp: got data 0x%0h required no response", resp_data);
            end
            if (exp_q.size() != 0) check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic ram_req_t mk(input logic wr, input int addr, input logic [15:0] data,
                                    input logic [1:0] strb);
        ram_req_t r = '0;
        r.wr        = wr;
        r.addr      = 32'(addr);
        r.data[15:0] = data;
        r.strb[1:0] = strb;
        return r;
    endfunction

    task automatic set_req(input ram_req_t r);
        req_valid   = 1'b1;
        req_addr    = r.addr[ADDR_W-1:0];
        req_wr      = r.wr;
        req_wr_data = r.data[DATA_W-1:0];
        req_wr_strb = r.strb[STRB_W-1:0];
    endtask

    task automatic issue(input ram_req_t r, input string tag);
        bit done = 1'b0;
        set_req(r);
        for (int t = 0; t < 20 && !done; t++) begin
            tick();
            done = acc_last;
        end
        req_valid = 1'b0;
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL %s: not accepted within 20 cycles, required acceptance", tag);
        end
    endtask

    task automatic drain(input string tag);
        resp_ready = 1'b1;
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n_acc;
        int n_gap;
        int n_busy;
        int pops_before;

        // Reset, preloading the RAM with a nonzero pattern.
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = pattern(i);
        rst = 1'b1;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'(BUSY_RST));

        rst = 1'b0;
        #1;
        check("first_req_ready", 32'(req_ready), 32'(READY_FIRST));

`ifdef TAXI_RAM_PORT_CTRL_INIT_EN
        n_busy = 0;
        for (int t = 0; t < 40 && busy; t++) begin
            n_busy++;
            tick();
        end
        check("init_busy_cycles", 32'(n_busy), 32'd16);
        check("init_done_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NWORDS; i++) issue(mk(1'b0, i, 16'h0, 2'b00), "init_rd");
        drain("init_drain");
        check("init_last_zero", 32'(last_resp), 32'd0);
`endif

        // Write then read with exact response latency.
        resp_ready = 1'b1;
        issue(mk(1'b1, 5, 16'hBEEF, 2'b11), "wr5");
        issue(mk(1'b0, 5, 16'h0, 2'b00), "rd5");
        #1;
        check("lat_t1_valid", 32'(resp_valid), 32'd0);
        tick();
        check("lat_t2_valid", 32'(resp_valid), 32'd1);
        check("lat_t2_data", 32'(resp_data), 32'hBEEF);
        drain("rd5_drain");

        // Streaming: 16 back-to-back reads with the consumer always ready.
        for (int i = 0; i < 16; i++) issue(mk(1'b1, i, 16'h1000 + 16'(i * 17), 2'b11), "stream_wr");
        pop_cyc_q.delete();
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(mk(1'b0, i, 16'h0, 2'b00));
            tick();
            if (acc_last) n_acc++;
        end
        req_valid = 1'b0;
        check("stream_accepts", 32'(n_acc), 32'd16);
        drain("stream_drain");
        check("stream_pops", 32'(pop_cyc_q.size()), 32'd16);
        n_gap = 0;
        for (int i = 1; i < pop_cyc_q.size(); i++)
            if (pop_cyc_q[i] != pop_cyc_q[i-1] + 1) n_gap++;
        check("stream_gaps", 32'(n_gap), 32'd0);

        // Backpressure: four credits, then the request side stalls.
        resp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(mk(1'b0, i + 3, 16'h0, 2'b00));
            tick();
            if (acc_last) n_acc++;
        end
        req_valid = 1'b0;
        #1;
        check("bp_accepts", 32'(n_acc), 32'd4);
        check("bp_req_ready_low", 32'(req_ready), 32'd0);
        check("bp_resp_stable", 32'(resp_data), 32'(ref_mem[3]));
        pop_cyc_q.delete();
        drain("bp_drain");
        check("bp_pops", 32'(pop_cyc_q.size()), 32'd4);
        check("bp_req_ready_back", 32'(req_ready), 32'd1);

        // Byte strobes merge into the existing word.
        issue(mk(1'b1, 2, 16'h1234, 2'b11), "strb_wr_full");
        issue(mk(1'b1, 2, 16'hAB00, 2'b10), "strb_wr_hi");
        issue(mk(1'b0, 2, 16'h0, 2'b00), "strb_rd");
        drain("strb_drain");
        check("strb_data", 32'(last_resp), 32'hAB34);

        // Reset with three reads outstanding discards them.
        resp_ready = 1'b0;
        issue(mk(1'b0, 7, 16'h0, 2'b00), "mid_rd7");
        issue(mk(1'b0, 8, 16'h0, 2'b00), "mid_rd8");
        issue(mk(1'b0, 9, 16'h0, 2'b00), "mid_rd9");
        rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        exp_q.delete();
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        pops_before = n_pop;
`ifdef TAXI_RAM_PORT_CTRL_INIT_EN
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        for (int t = 0; t < 40 && busy; t++) tick();
`endif
        for (int t = 0; t < 10; t++) tick();
        check("mid_no_stale", 32'(n_pop - pops_before), 32'd0);
        issue(mk(1'b0, 9, 16'h0, 2'b00), "post_rst_rd");
        drain("post_rst_drain");
        check("post_rst_pops", 32'(n_pop - pops_before), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
